// File: rtl/approx_prod_accum.sv
// Streaming dot-product accumulator for 16-bit approximate products: sums one
// vector at a time and presents sum, beat count and overflow status on a registered valid/ready port.
module approx_prod_accum #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter bit SAT     = 1'b1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic             out_sat,
    output logic             out_trunc
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_sat_q, out_sat_d;
    logic             out_trunc_q, out_trunc_d;
    logic             out_valid_q, out_valid_d;

    logic             beat_acc;
    logic             handoff;
    logic [ACC_W-1:0] acc_eff;
    logic [LEN_W-1:0] cnt_eff;
    logic             sat_eff;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] new_acc;
    logic [LEN_W-1:0] new_cnt;
    logic             new_sat;
    logic             close;

    // The input side only stalls when a finished result is stuck in the output register.
    assign in_ready = !out_valid_q || out_ready;
    assign beat_acc = in_valid && in_ready && !clr;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        acc_eff = (state_q == S_IDLE) ? '0 : acc_q;
        cnt_eff = (state_q == S_IDLE) ? '0 : cnt_q;
        sat_eff = (state_q == S_IDLE) ? 1'b0 : sat_q;
        sum     = {1'b0, acc_eff} + {{(ACC_W - 15){1'b0}}, in_prod};
        ovf     = sum[ACC_W];
        new_acc = (ovf && SAT) ? '1 : sum[ACC_W-1:0];
        new_sat = sat_eff | ovf;
        new_cnt = cnt_eff + LEN_W'(1);
        close   = in_last || (new_cnt == LEN_W'(MAX_LEN));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_len_d   = out_len_q;
        out_sat_d   = out_sat_q;
        out_trunc_d = out_trunc_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                out_valid_d = 1'b0;
            end
            if (beat_acc) begin
                if (close) begin
                    // A closing beat wins over a same-cycle hand-off, so out_valid stays high.
                    state_d     = S_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    out_sum_d   = new_acc;
                    out_len_d   = new_cnt;
                    out_sat_d   = new_sat;
                    out_trunc_d = !in_last;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = S_ACC;
                    acc_d   = new_acc;
                    cnt_d   = new_cnt;
                    sat_d   = new_sat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
            out_sat_q   <= 1'b0;
            out_trunc_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_len_q   <= out_len_d;
            out_sat_q   <= out_sat_d;
            out_trunc_q <= out_trunc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_len   = out_len_q;
    assign out_sat   = out_sat_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Scoreboard bench for approx_prod_accum: three configurations (default, 17-bit saturating
// with MAX_LEN 4, 17-bit wrapping) driven with directed vectors and hand-computed results.
module tb_approx_prod_accum;

    logic clk;
    logic rst_n;

    logic        clrIn    [3];
    logic        inValid  [3];
    logic        inReady  [3];
    logic [15:0] inProd   [3];
    logic        inLast   [3];
    logic        outValid [3];
    logic        outReady [3];
    logic [31:0] outSum   [3];
    logic [15:0] outLen   [3];
    logic        outSat   [3];
    logic        outTrunc [3];

    logic [23:0] sum0;
    logic [8:0]  len0;
    logic [16:0] sum1;
    logic [2:0]  len1;
    logic [16:0] sum2;
    logic [8:0]  len2;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] sum;
        logic [15:0] len;
        logic        sat;
        logic        trunc;
    } expT;

    expT expQ[$];
    expT monExp;

    int checks;
    int errors;

    // Instance 0: default parameters.
    approx_prod_accum u0 (
        .clk(clk), .rst_n(rst_n), .clr(clrIn[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_prod(inProd[0]), .in_last(inLast[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_sum(sum0), .out_len(len0), .out_sat(outSat[0]), .out_trunc(outTrunc[0])
    );

    // Instance 1: narrow saturating accumulator with a short length limit.
    approx_prod_accum #(.ACC_W(17), .MAX_LEN(4), .SAT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clrIn[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_prod(inProd[1]), .in_last(inLast[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_sum(sum1), .out_len(len1), .out_sat(outSat[1]), .out_trunc(outTrunc[1])
    );

    // Instance 2: narrow wrapping accumulator.
    approx_prod_accum #(.ACC_W(17), .MAX_LEN(256), .SAT(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clrIn[2]),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_prod(inProd[2]), .in_last(inLast[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_sum(sum2), .out_len(len2), .out_sat(outSat[2]), .out_trunc(outTrunc[2])
    );

    assign outSum[0] = 32'(sum0);
    assign outSum[1] = 32'(sum1);
    assign outSum[2] = 32'(sum2);
    assign outLen[0] = 16'(len0);
    assign outLen[1] = 16'(len1);
    assign outLen[2] = 16'(len2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something deadlocks despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int idx, input logic [31:0] sum, input int len,
                           input logic sat, input logic trunc);
        expT e;
        e.idx   = 2'(idx);
        e.sum   = sum;
        e.len   = 16'(len);
        e.sat   = sat;
        e.trunc = trunc;
        expQ.push_back(e);
    endtask

    task automatic syncUp();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns once it has been accepted; waits counts stalled cycles.
    task automatic applyStimulus(input int idx, input logic [15:0] prod, input logic last,
                                 output int waits);
        bit ok;
        inValid[idx] = 1'b1;
        inProd[idx]  = prod;
        inLast[idx]  = last;
        waits = 0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = inReady[idx] && !clrIn[idx];
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        inValid[idx] = 1'b0;
        inLast[idx]  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst %0d got no acceptance required acceptance", idx);
        end
    endtask

    task automatic waitDrain(input int bound);
        for (int n = 0; n < bound && expQ.size() != 0; n++) begin
            @(negedge clk);
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
        syncUp();
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(outValid[0]), 32'd0);
        checkOutput({tag, "_sum"},   outSum[0],        32'd0);
        checkOutput({tag, "_len"},   32'(outLen[0]),   32'd0);
        checkOutput({tag, "_sat"},   32'(outSat[0]),   32'd0);
        checkOutput({tag, "_trunc"}, 32'(outTrunc[0]), 32'd0);
        checkOutput({tag, "_ready"}, 32'(inReady[0]),  32'd1);
    endtask

    // Monitor: pops the scoreboard on every result hand-off.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_n && outValid[i] && outReady[i]) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result inst %0d got sum 0x%0h len %0d required none",
                                 i, outSum[i], outLen[i]);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput($sformatf("inst%0d_idx", i),   32'(monExp.idx), 32'(i));
                        checkOutput($sformatf("inst%0d_sum", i),   outSum[i],       monExp.sum);
                        checkOutput($sformatf("inst%0d_len", i),   32'(outLen[i]),  32'(monExp.len));
                        checkOutput($sformatf("inst%0d_sat", i),   32'(outSat[i]),  32'(monExp.sat));
                        checkOutput($sformatf("inst%0d_trunc", i), 32'(outTrunc[i]), 32'(monExp.trunc));
                    end
                end
            end
        end
    end

    initial begin
        int w;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clrIn[i]    = 1'b0;
            inValid[i]  = 1'b0;
            inProd[i]   = 16'h0;
            inLast[i]   = 1'b0;
            outReady[i] = 1'b1;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkZeroOutputs("reset");
        syncUp();
        rst_n = 1'b1;
        syncUp();

        // Three-beat vector, result visible one cycle after the closing beat.
        pushExp(0, 32'h60, 3, 1'b0, 1'b0);
        applyStimulus(0, 16'h0010, 1'b0, w);
        checkOutput("vec3_beat1_stall", 32'(w), 32'd0);
        applyStimulus(0, 16'h0020, 1'b0, w);
        checkOutput("vec3_beat2_stall", 32'(w), 32'd0);
        applyStimulus(0, 16'h0030, 1'b1, w);
        checkOutput("vec3_beat3_stall", 32'(w), 32'd0);
        @(negedge clk);
        checkOutput("vec3_latency_valid", 32'(outValid[0]), 32'd1);
        waitDrain(10);

        // Back-to-back single-beat vectors with no bubble.
        pushExp(0, 32'hFFFF, 1, 1'b0, 1'b0);
        pushExp(0, 32'h1, 1, 1'b0, 1'b0);
        applyStimulus(0, 16'hFFFF, 1'b1, w);
        applyStimulus(0, 16'h0001, 1'b1, w);
        checkOutput("b2b_stall", 32'(w), 32'd0);
        @(negedge clk);
        checkOutput("b2b_valid", 32'(outValid[0]), 32'd1);
        checkOutput("b2b_sum", outSum[0], 32'h1);
        waitDrain(10);

        // Zero-valued products still count.
        pushExp(0, 32'h3, 3, 1'b0, 1'b0);
        applyStimulus(0, 16'h0000, 1'b0, w);
        applyStimulus(0, 16'h0000, 1'b0, w);
        applyStimulus(0, 16'h0003, 1'b1, w);
        waitDrain(10);

        // Backpressure: result held, input stalled, then release with a closing beat.
        pushExp(0, 32'h7, 1, 1'b0, 1'b0);
        pushExp(0, 32'h9, 1, 1'b0, 1'b0);
        outReady[0] = 1'b0;
        applyStimulus(0, 16'h0007, 1'b1, w);
        inValid[0] = 1'b1;
        inProd[0]  = 16'h0009;
        inLast[0]  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d_ready", n), 32'(inReady[0]), 32'd0);
            checkOutput($sformatf("bp%0d_valid", n), 32'(outValid[0]), 32'd1);
            checkOutput($sformatf("bp%0d_sum", n),   outSum[0],        32'h7);
            checkOutput($sformatf("bp%0d_len", n),   32'(outLen[0]),   32'd1);
        end
        syncUp();
        outReady[0] = 1'b1;
        syncUp();
        inValid[0] = 1'b0;
        inLast[0]  = 1'b0;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(outValid[0]), 32'd1);
        checkOutput("bp_release_sum", outSum[0], 32'h9);
        waitDrain(10);

        // Mid-vector clr, with a closing beat presented in the clr cycle.
        pushExp(0, 32'h5, 1, 1'b0, 1'b0);
        applyStimulus(0, 16'h0100, 1'b0, w);
        applyStimulus(0, 16'h0100, 1'b0, w);
        clrIn[0]   = 1'b1;
        inValid[0] = 1'b1;
        inProd[0]  = 16'h0100;
        inLast[0]  = 1'b1;
        syncUp();
        clrIn[0]   = 1'b0;
        inValid[0] = 1'b0;
        inLast[0]  = 1'b0;
        @(negedge clk);
        checkOutput("clr_valid", 32'(outValid[0]), 32'd0);
        syncUp();
        applyStimulus(0, 16'h0005, 1'b1, w);
        waitDrain(10);

        // Mid-vector reset: everything drops, outputs read zero during reset.
        applyStimulus(0, 16'h0100, 1'b0, w);
        applyStimulus(0, 16'h0100, 1'b0, w);
        rst_n = 1'b0;
        @(negedge clk);
        checkZeroOutputs("midrst");
        syncUp();
        rst_n = 1'b1;
        syncUp();
        pushExp(0, 32'h5, 1, 1'b0, 1'b0);
        applyStimulus(0, 16'h0005, 1'b1, w);
        waitDrain(10);

        // Saturation at ACC_W=17, then MAX_LEN=4 truncation with clean sticky state.
        pushExp(1, 32'h1FFFF, 3, 1'b1, 1'b0);
        applyStimulus(1, 16'hFFFF, 1'b0, w);
        applyStimulus(1, 16'hFFFF, 1'b0, w);
        applyStimulus(1, 16'hFFFF, 1'b1, w);
        waitDrain(10);
        pushExp(1, 32'h4, 4, 1'b0, 1'b1);
        pushExp(1, 32'h2, 2, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1, 16'h0001, (n == 5), w);
            checkOutput($sformatf("trunc_beat%0d_stall", n), 32'(w), 32'd0);
        end
        waitDrain(10);

        // Wrapping at ACC_W=17, then a fresh vector with the flag cleared.
        pushExp(2, 32'h0FFFD, 3, 1'b1, 1'b0);
        pushExp(2, 32'h2, 1, 1'b0, 1'b0);
        applyStimulus(2, 16'hFFFF, 1'b0, w);
        applyStimulus(2, 16'hFFFF, 1'b0, w);
        applyStimulus(2, 16'hFFFF, 1'b1, w);
        applyStimulus(2, 16'h0002, 1'b1, w);
        waitDrain(10);

        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_prod_accum.md
# approx_prod_accum

Streaming accumulator that sits directly downstream of the 8x8 approximate multipliers. It consumes one 16-bit approximate product per beat and sums the products of a vector (a dot product) into a wide accumulator. It then presents the sum, the beat count and a saturation flag through a registered valid/ready output. It is the accumulate stage used to measure approximate-multiplier error at dot-product level.

## Interface
- ACC_W, 24: accumulator and result width; legal range 17..32.
- MAX_LEN, 256: maximum beats per vector; legal range 2..65535. LEN_W = $clog2(MAX_LEN+1).
- SAT, 1: 1 = saturate on overflow; 0 = wrap modulo 2^ACC_W.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort: discards the partial vector and any pending result.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage can accept a beat.
- in_prod  in  16  unsigned product (the multiplier's R output).
- in_last  in  1  this beat closes the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  vector sum.
- out_len  out  LEN_W  number of beats in the vector (1..MAX_LEN).
- out_sat  out  1  saturation (SAT=1) or wrap (SAT=0) occurred in this vector.
- out_trunc  out  1  vector was closed by the MAX_LEN limit, not by in_last.

## Operation
- Beat accepted when in_valid && in_ready. Result handed off when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready only; it never depends on in_valid or in_last.
- Internal state:
  - acc (ACC_W), cnt (LEN_W), sat_st (1);
  - FSM S_IDLE (cnt==0) / S_ACC (partial vector open);
  - output register set {out_sum, out_len, out_sat, out_trunc, out_valid}.
- Per accepted beat:
  - sum = acc + zero-extended in_prod, computed at ACC_W+1 bits. acc is treated as 0 in S_IDLE.
  - ovf = sum[ACC_W].
  - new_acc = (ovf && SAT) ? all-ones : sum[ACC_W-1:0].
  - new_sat = sat_st_eff | ovf, where sat_st_eff = 0 in S_IDLE.
  - new_cnt = cnt_eff + 1.
- Close condition: in_last || new_cnt == MAX_LEN.
  - On close: load the output registers with new_acc, new_cnt, new_sat and trunc = !in_last. Set out_valid. Return to S_IDLE with acc = 0, cnt = 0, sat_st = 0.
  - Otherwise: store new_acc, new_cnt and new_sat, and go to (or stay in) S_ACC.
- Once saturated, acc stays all-ones for the rest of the vector; further beats still count toward out_len.
- Transitions:
  - S_IDLE -> S_ACC on an accepted non-closing beat.
  - S_IDLE -> S_IDLE on an accepted closing beat (single-beat vector).
  - S_ACC -> S_IDLE on an accepted closing beat.
- Output handshake:
  - out_valid clears on hand-off unless a closing beat is accepted in the same cycle; in that case the new result loads and out_valid stays 1.
  - Output fields are stable while out_valid && !out_ready.
- clr:
  - Forces S_IDLE, acc = 0, cnt = 0, sat_st = 0, out_valid = 0.
  - A beat presented in the clr cycle is discarded even if in_ready = 1.
  - clr overrides both handshakes.
- in_prod = 0 beats are legal and count toward out_len.

## Timing
- Reset values (asynchronous, rst_n low):
  - out_valid = 0, out_sum = 0, out_len = 0, out_sat = 0, out_trunc = 0;
  - acc = 0, cnt = 0, S_IDLE.
  - in_ready = 1 while in reset and after release.
- Latency: out_valid rises on the clock edge that accepts the closing beat; the result is visible the next cycle.
- Throughput: one beat per cycle sustained while out_ready = 1, including back-to-back vectors with no bubble.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and the partial vector holds.
- Reset asserted mid-vector or with a result pending drops everything immediately; no partial result is ever emitted.

## Test plan
- Reset then a 3-beat vector 0x0010, 0x0020, 0x0030 (last on beat 3), out_ready = 1 -> one cycle after beat 3: out_sum = 0x000060, out_len = 3, out_sat = 0, out_trunc = 0. in_ready stays 1 throughout.
- Single-beat vector 0xFFFF with in_last -> out_sum = 0x00FFFF, out_len = 1. A second single-beat vector 0x0001 on the next cycle -> out_sum = 0x000001 with no bubble.
- ACC_W = 17, SAT = 1: beats 0xFFFF, 0xFFFF, 0xFFFF (last) -> out_sum = 0x1FFFF, out_sat = 1. Same run with SAT = 0 -> out_sum = 0x0FFFD, out_sat = 1.
- MAX_LEN = 4: six beats of 0x0001 with in_last only on beat 6 -> first result out_sum = 4, out_len = 4, out_trunc = 1; second result out_sum = 2, out_len = 2, out_trunc = 0.
- Backpressure: hold out_ready = 0 after a result -> in_ready = 0 and out_* stable for 5 cycles. Raise out_ready together with a closing beat -> the new result loads and out_valid stays 1.
- Mid-vector abort: two beats of 0x0100, then clr asserted together with a valid beat, then a 1-beat vector 0x0005 -> only output is out_sum = 5, out_len = 1. Repeat with rst_n pulsed mid-vector -> same result, and all outputs are 0 during reset.
